fetch_stage: RTL and testbench

Instruction-fetch stage directly downstream of the program counter. Takes the current PC and issues a single-outstanding request to instruction memory. Captures the returned word into the IF/ID pipeline register. Handles decode back-pressure with a one-entry skid buffer and squashes wrong-path fetches when a jump or branch redirect occurs. Drives pc_hold back to the PC so the PC advances exactly once per accepted instruction.

---
 rtl/fetch_stage.sv | 251 +++++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage sitting directly behind the program counter.
// Issues one instruction-memory request at a time for the current PC,
// captures the returned word into the IF/ID pipeline register and tells
// the PC when it may advance (pc_hold = 0 exactly once per accepted
// instruction, or on a redirect).
//
// Decode back-pressure is absorbed by a one-entry skid buffer: a response
// that arrives while IF/ID is occupied and decode is stalled is parked in
// the skid and moved into IF/ID once the stall drops.  A redirect (jump or
// branch) flushes IF/ID and the skid, and any response still in flight for
// the wrong path is dropped when it returns.
//
// Optional feature (compile-time macro FETCH_PERF_EN):
//   adds perf_fetched / perf_squashed, 32-bit wrapping event counters for
//   IF/ID loads and for discarded memory responses.
//
// Parameters:
//   ADDR_W     PC / instruction-memory word-address width
//   DATA_W     instruction width
//   NOP_INSTR  instruction placed in IF/ID on reset and on flush
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-high reset
//   pc             current PC (word address)
//   redirect       PC loads a jump/branch target on this edge
//   pc_hold        1 = PC must not advance on this edge
//   imem_req       request strobe, one cycle per request
//   imem_addr      request address (the current PC)
//   imem_rdata     returned instruction, valid with imem_ack
//   imem_ack       response strobe
//   id_stall       decode cannot accept a new IF/ID entry this cycle
//   if_id_valid    IF/ID entry valid
//   if_id_pc       PC of the IF/ID instruction
//   if_id_instr    IF/ID instruction
//   perf_fetched   (FETCH_PERF_EN only) count of IF/ID loads
//   perf_squashed  (FETCH_PERF_EN only) count of discarded responses
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                 ADDR_W    = 32,
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    output logic              pc_hold,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    input  logic              id_stall,
    output logic              if_id_valid,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed
`endif
);

    // REQ   : idle, a request goes out this cycle unless redirected
    // WAIT  : one request outstanding, its data is wanted
    // FULL  : response parked in the skid, waiting for decode
    // DRAIN : one request outstanding for a squashed path
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state, state_nx;

    // PC of the outstanding request and the skid buffer contents.  The
    // skid holds a valid entry exactly when the FSM is in FULL, so no
    // separate valid flag is kept.
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_instr;

    // Per-cycle event strobes decoded from the state and inputs.
    logic issue;      // request leaves this cycle
    logic load_mem;   // response goes straight into IF/ID
    logic to_skid;    // response parked in the skid
    logic load_skid;  // skid moves into IF/ID

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; redirect takes priority in every state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_REQ: begin
                if (!redirect) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    // A same-cycle redirect drops the data; otherwise the
                    // word goes to IF/ID or, under stall, to the skid.
                    if (redirect || !if_id_valid || !id_stall) begin
                        state_nx = S_REQ;
                    end else begin
                        state_nx = S_FULL;
                    end
                end else if (redirect) begin
                    state_nx = S_DRAIN;
                end
            end
            S_FULL: begin
                if (redirect || !id_stall) begin
                    state_nx = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        pc_hold   = 1'b1;
        issue     = 1'b0;
        load_mem  = 1'b0;
        to_skid   = 1'b0;
        load_skid = 1'b0;
        case (state)
            S_REQ: begin
                issue    = !redirect;
                imem_req = !redirect;
            end
            S_WAIT: begin
                if (imem_ack && !redirect) begin
                    // The PC advances as soon as the word is accepted,
                    // whether into IF/ID or into the skid.
                    pc_hold  = 1'b0;
                    load_mem = !if_id_valid || !id_stall;
                    to_skid  = if_id_valid && id_stall;
                end
            end
            S_FULL: begin
                load_skid = !id_stall && !redirect;
            end
            S_DRAIN: begin
            end
            default: begin
            end
        endcase
        // The PC loads its target on a redirect regardless of state.
        if (redirect) begin
            pc_hold = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register and outstanding-request PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pc      <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else begin
            if (issue) begin
                req_pc <= pc;
            end
            // Flush overrides both loads and the decode stall; the PC
            // field is left alone so it still names the last fetched slot.
            if (redirect) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
            end else if (load_mem) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= req_pc;
                if_id_instr <= imem_rdata;
            end else if (load_skid) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= skid_pc;
                if_id_instr <= skid_instr;
            end else if (!id_stall) begin
                // Decode consumed the entry and nothing replaced it.
                if_id_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer data (occupancy is tracked by the FSM)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (to_skid) begin
            skid_pc    <= req_pc;
            skid_instr <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic discard;

    // A response is thrown away when it lands in DRAIN, or in WAIT on
    // the same edge as a redirect.  Acks in REQ/FULL are illegal and
    // are not counted.
    assign discard = imem_ack &&
                     ((state == S_DRAIN) || ((state == S_WAIT) && redirect));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            if (load_mem || load_skid) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (discard) begin
                perf_squashed <= perf_squashed + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Randomised bench for fetch_stage.  The bench plays both the PC (advances
// when allowed, loads targets on redirect) and an instruction memory with
// a random 1..3 cycle response latency plus occasional stray acks.  The
// expected behaviour comes from a transaction-level model: one in-flight
// request record (with a "killed" mark), a queue of parked responses, and
// the IF/ID contents.  Asynchronous resets are injected while a response
// is parked behind a decode stall.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int             AW  = 32;
    localparam int             DW  = 32;
    localparam logic [DW-1:0]  NOP = 32'h0000_0013;
    localparam int             N_CYC = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          redirect;
    logic          pc_hold;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          imem_ack;
    logic          id_stall;
    logic          if_id_valid;
    logic [AW-1:0] if_id_pc;
    logic [DW-1:0] if_id_instr;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_squashed;
`endif

    fetch_stage #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .redirect    (redirect),
        .pc_hold     (pc_hold),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .id_stall    (id_stall),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } entry_t;

    bit            o_busy;   // a request is in flight
    bit            o_kill;   // ...and it belongs to a squashed path
    logic [AW-1:0] o_pc;
    entry_t        held[$];  // responses accepted but not yet in IF/ID
    bit            m_vld;
    logic [AW-1:0] m_pc;
    logic [DW-1:0] m_ins;
    int unsigned   m_fetched;
    int unsigned   m_squashed;

    // ---------------- environment ----------------
    bit            mem_busy;
    int            mem_cnt;
    logic [AW-1:0] mem_addr;
    bit            stray_next;
    logic [AW-1:0] tgt;
    bit            was_req;
    bit            e_req;
    bit            e_hold;
    int            n_resets;

    task automatic model_reset();
        o_busy = 0; o_kill = 0; o_pc = '0;
        held.delete();
        m_vld = 0; m_pc = '0; m_ins = NOP;
        m_fetched = 0; m_squashed = 0;
        mem_busy = 0; mem_cnt = 0;
    endtask

    task automatic check_outputs();
        check("imem_req", 64'(imem_req), 64'(e_req));
        if (e_req) check("imem_addr", 64'(imem_addr), 64'(pc));
        check("pc_hold", 64'(pc_hold), 64'(e_hold));
        check("if_id_valid", 64'(if_id_valid), 64'(m_vld));
        check("if_id_pc", 64'(if_id_pc), 64'(m_pc));
        check("if_id_instr", 64'(if_id_instr), 64'(m_ins));
`ifdef FETCH_PERF_EN
        check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        check("perf_squashed", 64'(perf_squashed), 64'(m_squashed));
`endif
    endtask

    // Advance the model across one clock edge using the inputs that were
    // applied during the cycle.
    task automatic model_step();
        entry_t got;
        bit     have;
        bit     loaded;
        have   = 0;
        loaded = 0;
        if (redirect) begin
            m_vld = 0;
            m_ins = NOP;
            held.delete();
            if (o_busy) begin
                if (imem_ack) begin
                    o_busy = 0;
                    m_squashed++;
                end else begin
                    o_kill = 1;
                end
            end
        end else begin
            if (o_busy && imem_ack) begin
                o_busy = 0;
                if (o_kill) m_squashed++;
                else begin
                    have = 1;
                    got  = '{o_pc, imem_rdata};
                end
            end
            if (have) begin
                if (!m_vld || !id_stall) begin
                    m_vld = 1; m_pc = got.pc; m_ins = got.ins; loaded = 1;
                end else begin
                    held.push_back(got);
                end
            end else if (held.size() > 0 && !id_stall) begin
                got = held.pop_front();
                m_vld = 1; m_pc = got.pc; m_ins = got.ins; loaded = 1;
            end
            if (!loaded && !id_stall) m_vld = 0;
            if (loaded) m_fetched++;
            if (was_req) begin
                o_busy = 1; o_kill = 0; o_pc = pc;
            end
        end
        // memory
        if (mem_busy) begin
            if (imem_ack) mem_busy = 0;
            else mem_cnt--;
        end
        if (e_req) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(0, 2);
            mem_addr = pc;
        end
        // program counter
        if (redirect) pc = tgt;
        else if (!e_hold) pc = pc + 1'b1;
    endtask

    initial begin
        rst = 1'b1; pc = '0; redirect = 0; id_stall = 0;
        imem_ack = 0; imem_rdata = '0; tgt = '0;
        stray_next = 0; n_resets = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        e_req = 1; e_hold = 1;
        check_outputs();
        rst = 1'b0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            // drive inputs for this cycle
            redirect = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           tgt = 32'($urandom_range(0, 63));
            id_stall = ($urandom_range(0, 99) < 35);
            if (mem_busy && mem_cnt == 0) begin
                imem_ack   = 1;
                imem_rdata = mem_word(mem_addr);
            end else if (!mem_busy && (stray_next || $urandom_range(0, 99) < 4)) begin
                imem_ack   = 1;
                imem_rdata = $urandom;
            end else begin
                imem_ack   = 0;
                imem_rdata = $urandom;
            end
            stray_next = 0;
            was_req = !o_busy && held.size() == 0;
            e_req   = was_req && !redirect;
            e_hold  = !(redirect || (o_busy && !o_kill && imem_ack));
            #3;
            check_outputs();

            if (held.size() > 0 && n_resets < 4 && $urandom_range(0, 3) == 0) begin
                // asynchronous reset while a response is parked
                n_resets++;
                rst = 1'b1; redirect = 0; imem_ack = 0; pc = '0;
                #1;
                model_reset();
                e_req = 1; e_hold = 1;
                check_outputs();
                @(posedge clk);
                #1;
                rst = 1'b0;
                stray_next = 1;   // late ack right after reset must be ignored
            end else begin
                @(posedge clk);
                #1;
                model_step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
